// File: rtl/counter_extend_pkg.sv
// Shared constants and snapshot layout for the Counter4 wrap-count extender.
// Snapshot is {hi, lo}: the wrap count on top of the raw 4-bit counter value.
package counter_extend_pkg;

  localparam int HI_W_DEF = 8;
  localparam int LO_W     = 4;

  typedef struct packed {
    logic [HI_W_DEF-1:0] hi;
    logic [LO_W-1:0]     lo;
  } snap_t;

  // On a wrap cycle the counter sits at 15; pinning lo keeps the snapshot monotonic.
  function automatic logic [LO_W-1:0] snap_lo(input logic cin, input logic [LO_W-1:0] i);
    return cin ? {LO_W{1'b1}} : i;
  endfunction

endpackage

// File: rtl/counter_extend_hs.sv
// Valid/ready snapshot holding register; one-cycle load latency.
// Backpressure: VALID=1 with READY=0 holds data; a new capture then is dropped (drop_o with COUNTER_EXTEND_MISS_EN).
module counter_extend_hs #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cap_i,
  input  logic         rdy_i,
  input  logic [W-1:0] din_i,
`ifdef COUNTER_EXTEND_MISS_EN
  output logic         drop_o,
`endif
  output logic         vld_o,
  output logic [W-1:0] dat_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;
  logic         accept;

  always_comb begin
    accept = cap_i && (!vld_q || rdy_i);
    vld_d  = vld_q;
    dat_d  = dat_q;
    if (accept) begin
      vld_d = 1'b1;
      dat_d = din_i;
    end else if (rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

`ifdef COUNTER_EXTEND_MISS_EN
  assign drop_o = cap_i && vld_q && !rdy_i;
`endif
  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/counter_extend.sv
// Extends a 4-bit Counter4 with an HI_W-bit wrap count and a valid/ready snapshot port; MISS flag with COUNTER_EXTEND_MISS_EN.
// Latency: HI and snapshot update on the edge after CIN/CAPTURE. Backpressure: counting never stalls; captures while held are dropped.
module counter_extend
  import counter_extend_pkg::*;
#(
  parameter int HI_W = HI_W_DEF
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CIN,
  input  logic [LO_W-1:0]      I,
  input  logic                 CAPTURE,
  input  logic                 READY,
`ifdef COUNTER_EXTEND_MISS_EN
  output logic                 MISS,
`endif
  output logic [HI_W-1:0]      HI,
  output logic                 VALID,
  output logic [HI_W+LO_W-1:0] O,
  output logic                 OVF
);

  logic [HI_W-1:0]      hi_q, hi_d;
  logic                 ovf_q, ovf_d;
  logic [HI_W+LO_W-1:0] snap_in;

  always_comb begin
    hi_d  = CIN ? hi_q + HI_W'(1) : hi_q;
    ovf_d = ovf_q || (CIN && (&hi_q));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hi_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      ovf_q <= ovf_d;
    end
  end

  // Pre-increment HI is sampled, so a capture on the wrap cycle reads {HI, 15}.
  assign snap_in = {hi_q, snap_lo(CIN, I)};

`ifdef COUNTER_EXTEND_MISS_EN
  logic drop;
  logic miss_q, miss_d;

  always_comb begin
    miss_d = miss_q || drop;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      miss_q <= 1'b0;
    end else begin
      miss_q <= miss_d;
    end
  end

  assign MISS = miss_q;
`endif

  counter_extend_hs #(
    .W(HI_W + LO_W)
  ) u_hs (
    .clk    (CLK),
    .rst    (RESET),
    .cap_i  (CAPTURE),
    .rdy_i  (READY),
    .din_i  (snap_in),
`ifdef COUNTER_EXTEND_MISS_EN
    .drop_o (drop),
`endif
    .vld_o  (VALID),
    .dat_o  (O)
  );

  assign HI  = hi_q;
  assign OVF = ovf_q;

endmodule

// File: tb/tb_counter_extend.sv
// Bench for counter_extend: vector table plus wrap/overflow/reset sequences, scoreboard checked every cycle.
// Covers the MISS port when built with COUNTER_EXTEND_MISS_EN.
module tb_counter_extend;
  import counter_extend_pkg::*;

  localparam int HI_W = 8;

  logic            CLK = 1'b0;
  logic            RESET, CIN, CAPTURE, READY;
  logic [3:0]      I;
  logic [HI_W-1:0] HI;
  logic            VALID, OVF;
  logic [HI_W+3:0] O;
`ifdef COUNTER_EXTEND_MISS_EN
  logic            MISS;
`endif

  counter_extend #(.HI_W(HI_W)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .CIN     (CIN),
    .I       (I),
    .CAPTURE (CAPTURE),
    .READY   (READY),
`ifdef COUNTER_EXTEND_MISS_EN
    .MISS    (MISS),
`endif
    .HI      (HI),
    .VALID   (VALID),
    .O       (O),
    .OVF     (OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [HI_W-1:0] hi;
    logic            vld;
    logic [HI_W+3:0] o;
    logic            ovf;
    logic            miss;
  } exp_t;

  typedef struct {
    logic            rst, cin;
    logic [3:0]      i;
    logic            cap, rdy;
    logic [HI_W-1:0] hi;
    logic            vld;
    logic [HI_W+3:0] o;
    logic            ovf, miss;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state
  logic [HI_W-1:0] m_hi = '0;
  logic            m_vld = 1'b0;
  logic [HI_W+3:0] m_o = '0;
  logic            m_ovf = 1'b0;
  logic            m_miss = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic cin, input logic [3:0] i,
                      input logic cap, input logic rdy);
    exp_t e;
    RESET = rst; CIN = cin; I = i; CAPTURE = cap; READY = rdy;
    if (rst) begin
      m_hi = '0; m_vld = 1'b0; m_o = '0; m_ovf = 1'b0; m_miss = 1'b0;
    end else begin
      if (cap && m_vld && !rdy) m_miss = 1'b1;
      if (cap && (!m_vld || rdy)) begin
        m_o   = {m_hi, i};
        m_vld = 1'b1;
      end else if (rdy) begin
        m_vld = 1'b0;
      end
      if (cin && m_hi == {HI_W{1'b1}}) m_ovf = 1'b1;
      if (cin) m_hi = m_hi + 1'b1;
    end
    e.hi = m_hi; e.vld = m_vld; e.o = m_o; e.ovf = m_ovf; e.miss = m_miss;
    sb.push_back(e);
    @(posedge CLK); #1;
    e = sb.pop_front();
    chk("sb_hi", 32'(HI), 32'(e.hi));
    chk("sb_valid", 32'(VALID), 32'(e.vld));
    chk("sb_o", 32'(O), 32'(e.o));
    chk("sb_ovf", 32'(OVF), 32'(e.ovf));
`ifdef COUNTER_EXTEND_MISS_EN
    chk("sb_miss", 32'(MISS), 32'(e.miss));
`endif
  endtask

  function automatic vec_t mk(logic rst, logic cin, logic [3:0] i, logic cap, logic rdy,
                              logic [HI_W-1:0] hi, logic vld, logic [HI_W+3:0] o,
                              logic ovf, logic miss);
    vec_t v;
    v.rst = rst; v.cin = cin; v.i = i; v.cap = cap; v.rdy = rdy;
    v.hi = hi; v.vld = vld; v.o = o; v.ovf = ovf; v.miss = miss;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t  tbl[14];
    snap_t s;

    //            rst cin  i    cap rdy  hi     vld  o        ovf miss
    tbl[0]  = mk(1, 0, 4'd0,  0, 0, 8'd0, 0, 12'h000, 0, 0);
    tbl[1]  = mk(0, 1, 4'd15, 0, 0, 8'd1, 0, 12'h000, 0, 0);
    tbl[2]  = mk(0, 1, 4'd15, 0, 0, 8'd2, 0, 12'h000, 0, 0);
    tbl[3]  = mk(0, 1, 4'd15, 0, 0, 8'd3, 0, 12'h000, 0, 0);
    tbl[4]  = mk(0, 1, 4'd15, 1, 0, 8'd4, 1, 12'h03F, 0, 0);  // capture on wrap
    tbl[5]  = mk(0, 0, 4'd7,  1, 0, 8'd4, 1, 12'h03F, 0, 1);  // dropped x3
    tbl[6]  = mk(0, 0, 4'd8,  1, 0, 8'd4, 1, 12'h03F, 0, 1);
    tbl[7]  = mk(0, 0, 4'd9,  1, 0, 8'd4, 1, 12'h03F, 0, 1);
    tbl[8]  = mk(0, 1, 4'd15, 0, 1, 8'd5, 0, 12'h03F, 0, 1);  // drain
    tbl[9]  = mk(0, 0, 4'd2,  1, 1, 8'd5, 1, 12'h052, 0, 1);
    tbl[10] = mk(0, 0, 4'd2,  1, 1, 8'd5, 1, 12'h052, 0, 1);  // back-to-back
    tbl[11] = mk(0, 0, 4'd3,  0, 1, 8'd5, 0, 12'h052, 0, 1);
    tbl[12] = mk(0, 0, 4'd4,  0, 1, 8'd5, 0, 12'h052, 0, 1);  // READY idle
    tbl[13] = mk(1, 1, 4'd15, 1, 1, 8'd0, 0, 12'h000, 0, 0);  // reset wins

    RESET = 1'b1; CIN = 1'b0; I = 4'd0; CAPTURE = 1'b0; READY = 1'b0;
    @(posedge CLK); #1;

    for (int k = 0; k < 14; k++) begin
      step(tbl[k].rst, tbl[k].cin, tbl[k].i, tbl[k].cap, tbl[k].rdy);
      chk($sformatf("tbl%0d_hi", k), 32'(HI), 32'(tbl[k].hi));
      chk($sformatf("tbl%0d_valid", k), 32'(VALID), 32'(tbl[k].vld));
      chk($sformatf("tbl%0d_o", k), 32'(O), 32'(tbl[k].o));
      chk($sformatf("tbl%0d_ovf", k), 32'(OVF), 32'(tbl[k].ovf));
`ifdef COUNTER_EXTEND_MISS_EN
      chk($sformatf("tbl%0d_miss", k), 32'(MISS), 32'(tbl[k].miss));
`endif
    end

    // 17 full Counter4 sweeps
    step(1, 0, 4'd0, 0, 0);
    for (int w = 0; w < 17; w++)
      for (int v = 0; v < 16; v++)
        step(0, v == 15, 4'(v), 0, 0);
    chk("wrap17_hi", 32'(HI), 32'd17);
    chk("wrap17_ovf", 32'(OVF), 32'd0);

    // Overflow of HI after 256 wraps, sticky afterwards
    step(1, 0, 4'd0, 0, 0);
    repeat (255) step(0, 1, 4'd15, 0, 0);
    chk("wrap255_hi", 32'(HI), 32'd255);
    chk("wrap255_ovf", 32'(OVF), 32'd0);
    step(0, 1, 4'd15, 0, 0);
    chk("wrap256_hi", 32'(HI), 32'd0);
    chk("wrap256_ovf", 32'(OVF), 32'd1);
    repeat (9) step(0, 1, 4'd15, 0, 0);
    chk("ovf_sticky_hi", 32'(HI), 32'd9);
    chk("ovf_sticky", 32'(OVF), 32'd1);

    // Reset mid-handshake with a concurrent capture
    step(0, 0, 4'd1, 1, 0);
    s = snap_t'(O);
    chk("pre_rst_valid", 32'(VALID), 32'd1);
    chk("pre_rst_snap_hi", 32'(s.hi), 32'd9);
    chk("pre_rst_snap_lo", 32'(s.lo), 32'd1);
    step(1, 0, 4'd3, 1, 1);
    chk("rst_hi", 32'(HI), 32'd0);
    chk("rst_valid", 32'(VALID), 32'd0);
    chk("rst_o", 32'(O), 32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    step(0, 0, 4'd6, 1, 0);
    chk("post_rst_valid", 32'(VALID), 32'd1);
    chk("post_rst_o", 32'(O), 32'h006);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_extend.md
COUNTER_EXTEND -- requirements
Module: counter_extend

Interface
REQ-001 Parameter: HI_W, default 8, width of the wrap (high-order) count extending the 4-bit Counter4 value.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 CIN  input  1  Counter4 COUT; high while the counter value is 15, i.e. the counter wraps at the next edge.
REQ-005 I  input  4  current Counter4 value O[3:0].
REQ-006 CAPTURE  input  1  one-cycle request to snapshot the extended count.
REQ-007 READY  input  1  downstream accepts the snapshot this cycle.
REQ-008 HI  output  HI_W  live wrap count.
REQ-009 VALID  output  1  snapshot held on O.
REQ-010 O  output  HI_W+4  snapshot {HI, I}.
REQ-011 OVF  output  1  sticky: HI has wrapped past all-ones.
REQ-012 MISS  output  1  sticky: a capture was dropped; present only with COUNTER_EXTEND_MISS_EN.

Function
REQ-013 HI SHALL increment by 1 modulo 2^HI_W on each edge where CIN=1; otherwise hold.
REQ-014 OVF SHALL set on the edge where CIN=1 and HI=all-ones (HI becomes 0), and hold until RESET.
REQ-015 A capture is accepted when CAPTURE=1 and (VALID=0 or READY=1).
REQ-016 On an accepted capture, O SHALL load {HI, I} as sampled in that cycle (pre-increment HI), and VALID SHALL be 1 after that edge (one-cycle latency).
REQ-017 CAPTURE and CIN in the same cycle: snapshot SHALL hold pre-increment HI with I=15, so O is monotonic across the wrap.
REQ-018 VALID=1 and READY=1 with no capture: VALID SHALL clear after the edge; O holds its last value.
REQ-019 VALID=1, READY=1, CAPTURE=1: new snapshot loaded, VALID stays 1 (back-to-back, no bubble).
REQ-020 VALID=1, READY=0: O and VALID SHALL remain stable; a CAPTURE this cycle is dropped.
REQ-021 READY while VALID=0 SHALL have no effect.
REQ-022 HI counting SHALL be independent of the handshake and never stall.

Reset
REQ-023 On an edge with RESET=1: HI=0, VALID=0, O=0, OVF=0, MISS=0; RESET overrides CIN, CAPTURE and READY in that cycle.
REQ-024 RESET mid-handshake SHALL discard the pending snapshot; no acceptance is implied.
REQ-025 First capture is possible in the cycle after RESET deasserts.

Configuration
REQ-026 Macro COUNTER_EXTEND_MISS_EN defined: MISS port exists, sets on the edge after a dropped capture (REQ-020), sticky until RESET.
REQ-027 Macro undefined: MISS port and its register absent; dropped captures are silent; all other behaviour identical.

Structure
REQ-028 Package counter_extend_pkg SHALL hold HI_W default constant, LO_W=4 constant, and the snapshot typedef {hi, lo}.
REQ-029 One sub-module counter_extend_hs SHALL implement the VALID/READY holding register (load, hold, drop decision); wrap counter and flags live in the top.

Verification
REQ-030 RESET, then drive I 0..15 repeating with CIN=1 at I=15 for 17 wraps -> HI=17, OVF=0.
REQ-031 HI_W=8, 256 wraps -> HI=0, OVF=1 after the 256th wrap edge, stays 1 until RESET.
REQ-032 HI=3, I=15, CIN=1, CAPTURE=1, READY=0 -> next cycle VALID=1, O=0x03F, HI=4.
REQ-033 VALID=1, READY=0, CAPTURE=1 for 3 cycles -> O unchanged, VALID=1; MISS=1 with macro, port absent without.
REQ-034 VALID=1, READY=1, CAPTURE=1 with HI=5, I=2 -> O=0x052, VALID stays 1; following cycle READY=1, CAPTURE=0 -> VALID=0.
REQ-035 VALID=1, OVF=1, HI=9, RESET=1 for one cycle together with CAPTURE=1 -> HI=0, VALID=0, O=0, OVF=0.
